// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, the schedule word type and the one-bit left rotate
// used by the message-schedule expander.
package sha1_pkg;

    localparam int WORD_W = 32;
    localparam int N_IN   = 16;
    localparam int N_OUT  = 80;
    localparam int CNT_W  = 8;
    localparam int IDX_W  = $clog2(N_OUT);

    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t rotl1(input word_t x);
        return {x[WORD_W-2:0], x[WORD_W-1]};
    endfunction

endpackage

// File: rtl/sha1_msg_schedule_if.sv
// Block-in / schedule-out bundle between the hashing datapath and the
// message-schedule expander.
interface sha1_msg_schedule_if;
    import sha1_pkg::*;

    logic             ext_en;
    word_t            hash_data [N_IN];
    logic [CNT_W-1:0] msg_cnt;
    word_t            msg [N_OUT];
    logic             ext_done;

    modport master (
        output ext_en,
        output hash_data,
        input  msg_cnt,
        input  msg,
        input  ext_done
    );

    modport slave (
        input  ext_en,
        input  hash_data,
        output msg_cnt,
        output msg,
        output ext_done
    );

endinterface

// File: rtl/sha1_msg_counter.sv
// Step counter for the schedule expander: runs 16..80, saturates at 80 and
// raises ext_done on the edge that writes the last word.
module sha1_msg_counter
    import sha1_pkg::*;
(
    input  logic             clk,
    input  logic             rst_ext_n,
    input  logic             ext_en,
    output logic [CNT_W-1:0] msg_cnt,
    output logic             step_en,
    output logic             ext_done
);

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(N_IN);
    localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(N_OUT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_END - CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_END) ? CNT_END : c + CNT_W'(1);
    endfunction

    assign step_en = ext_en && (msg_cnt < CNT_END);

    // Counter and done flag advance together so ext_done lands with msg_cnt==80
    always_ff @(posedge clk) begin
        if (!rst_ext_n) begin
            msg_cnt  <= CNT_START;
            ext_done <= 1'b0;
        end else if (step_en) begin
            msg_cnt  <= sat_inc(msg_cnt);
            ext_done <= (msg_cnt == CNT_LAST);
        end
    end

endmodule

// File: rtl/sha1_msg_schedule.sv
// SHA-1 message-schedule expander: loads a 16-word block on reset and fills
// W[16..79] one word per enabled clock using the 4-tap XOR/rotate recurrence.
module sha1_msg_schedule
    import sha1_pkg::*;
(
    input  logic          clk,
    input  logic          rst_ext_n,
    sha1_msg_schedule_if.slave bus
);

    logic             step_en;
    logic [CNT_W-1:0] msg_cnt;
    logic [IDX_W-1:0] wr_idx;
    word_t            w_new;
    word_t            msg_q [N_OUT];

    sha1_msg_counter u_counter (
        .clk       (clk),
        .rst_ext_n (rst_ext_n),
        .ext_en    (bus.ext_en),
        .msg_cnt   (msg_cnt),
        .step_en   (step_en),
        .ext_done  (bus.ext_done)
    );

    assign bus.msg_cnt = msg_cnt;
    assign bus.msg     = msg_q;

    // msg_cnt never exceeds 80, so its low bits are a valid array index
    assign wr_idx = msg_cnt[IDX_W-1:0];

    assign w_new = rotl1(msg_q[wr_idx - IDX_W'(3)]  ^
                         msg_q[wr_idx - IDX_W'(8)]  ^
                         msg_q[wr_idx - IDX_W'(14)] ^
                         msg_q[wr_idx - IDX_W'(16)]);

    always_ff @(posedge clk) begin
        if (!rst_ext_n) begin
            for (int i = 0; i < N_IN; i++)
                msg_q[i] <= bus.hash_data[i];
            for (int i = N_IN; i < N_OUT; i++)
                msg_q[i] <= '0;
        end else if (step_en) begin
            msg_q[wr_idx] <= w_new;
        end
    end

endmodule

// File: tb/tb_sha1_msg_schedule.sv
// Scoreboard bench for sha1_msg_schedule: the driver predicts the state after
// every clock from a precomputed SHA-1 schedule; a monitor compares each cycle.
module tb_sha1_msg_schedule;
    import sha1_pkg::*;

    logic clk = 1'b0;
    logic rst_ext_n;

    sha1_msg_schedule_if intf ();

    sha1_msg_schedule dut (
        .clk       (clk),
        .rst_ext_n (rst_ext_n),
        .bus       (intf.slave)
    );

    always #5 clk = ~clk;

    word_t blk [N_IN];
    word_t m_sched [N_OUT];
    int    m_k;
    int    exp_q [$];
    int    checks   = 0;
    int    failures = 0;

    // Full 80-word SHA-1 schedule for the current block, straight from the definition
    task automatic compute_sched();
        word_t x;
        for (int t = 0; t < N_OUT; t++) begin
            if (t < N_IN) begin
                m_sched[t] = blk[t];
            end else begin
                x = m_sched[t-3] ^ m_sched[t-8] ^ m_sched[t-14] ^ m_sched[t-16];
                m_sched[t] = (x << 1) | (x >> 31);
            end
        end
    endtask

    // One clock of stimulus; the predicted post-edge state is queued as k = words computed
    task automatic step(input logic rn, input logic en);
        @(negedge clk);
        rst_ext_n   = rn;
        intf.ext_en = en;
        if (!rn) begin
            for (int i = 0; i < N_IN; i++) intf.hash_data[i] = blk[i];
            compute_sched();
            m_k = 0;
        end else begin
            for (int i = 0; i < N_IN; i++) intf.hash_data[i] = $urandom;
            if (en && m_k < 64) m_k++;
        end
        exp_q.push_back(m_k);
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) step(1'b1, en);
    endtask

    task automatic random_block();
        for (int i = 0; i < N_IN; i++) blk[i] = $urandom;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
        end
    endtask

    // Monitor: compares msg_cnt, ext_done and the whole schedule after every predicted edge
    initial begin : monitor
        int    k;
        int    bad;
        word_t want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                k = exp_q.pop_front();
                checks++;
                if (intf.msg_cnt !== 8'(16 + k)) begin
                    failures++;
                    $display("FAIL msg_cnt: got %0d want %0d", intf.msg_cnt, 16 + k);
                end
                checks++;
                if (intf.ext_done !== (k == 64)) begin
                    failures++;
                    $display("FAIL ext_done: got %b want %b (words=%0d)", intf.ext_done, (k == 64), 16 + k);
                end
                bad = -1;
                for (int i = 0; i < N_OUT; i++) begin
                    want = (i < 16 + k) ? m_sched[i] : '0;
                    if (bad < 0 && intf.msg[i] !== want) bad = i;
                end
                checks++;
                if (bad >= 0) begin
                    failures++;
                    want = (bad < 16 + k) ? m_sched[bad] : '0;
                    $display("FAIL msg[%0d]: got 0x%08h want 0x%08h (words=%0d)", bad, intf.msg[bad], want, 16 + k);
                end
            end
        end
    end

    initial begin : driver
        rst_ext_n   = 1'b0;
        intf.ext_en = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            blk[i]            = '0;
            intf.hash_data[i] = '0;
        end
        m_k = 0;

        // Counting block with word 10 replaced
        for (int i = 0; i < N_IN; i++) blk[i] = 32'(i);
        blk[10] = 32'h14;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        run(63, 1'b1);
        @(posedge clk); #2;
        check_val("done_after_63", 32'(intf.ext_done), 32'd0);
        run(1, 1'b1);
        @(posedge clk); #2;
        check_val("done_after_64", 32'(intf.ext_done), 32'd1);
        check_val("cnt_at_done", 32'(intf.msg_cnt), 32'd80);
        check_val("W16", intf.msg[16], 32'h0000000E);
        check_val("W17", intf.msg[17], 32'h0000000A);
        check_val("W18", intf.msg[18], 32'h0000003A);
        check_val("W19", intf.msg[19], 32'h00000006);
        run(4, 1'b1);
        run(2, 1'b0);

        // Rotate wrap of the top bit
        for (int i = 0; i < N_IN; i++) blk[i] = '0;
        blk[0] = 32'h80000000;
        step(1'b0, 1'b1);
        run(66, 1'b1);
        @(posedge clk); #2;
        check_val("W16_wrap", intf.msg[16], 32'h00000001);

        // All-zero block
        for (int i = 0; i < N_IN; i++) blk[i] = '0;
        step(1'b0, 1'b0);
        run(64, 1'b1);
        run(2, 1'b1);

        // Pause at msg_cnt==40
        random_block();
        step(1'b0, 1'b1);
        run(24, 1'b1);
        run(5, 1'b0);
        run(42, 1'b1);

        // Reset mid-expansion at msg_cnt==50 with a fresh block
        random_block();
        step(1'b0, 1'b1);
        run(34, 1'b1);
        random_block();
        step(1'b0, 1'b1);
        run(66, 1'b1);

        // Random blocks with random enable, occasional mid-run resets
        for (int r = 0; r < 3; r++) begin
            random_block();
            step(1'b0, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 110; c++) begin
                if ($urandom_range(0, 199) == 0) begin
                    random_block();
                    step(1'b0, 1'($urandom_range(0, 1)));
                end else begin
                    step(1'b1, 1'($urandom_range(0, 3) != 0));
                end
            end
        end

        repeat (3) @(posedge clk);
        #2;
        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
